mux4_rr_scheduler: RTL

MUX4_RR_SCHEDULER -- requirements
Module: mux4_rr_scheduler

---
 rtl/mux4_rr_scheduler_pkg.sv | 11 +
 rtl/mux4_rr_scheduler_pick.sv | 23 ++
 rtl/mux4_rr_scheduler.sv | 68 ++++++
 3 files changed

// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared constants and state encoding for the 4-way round-robin output scheduler.
package mux4_rr_scheduler_pkg;
    localparam int DATA_W = 16;
    localparam int N_REQ  = 4;
    localparam int SRC_W  = 2;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;
endpackage

// File: rtl/mux4_rr_scheduler_pick.sv
// Combinational rotating-priority picker: first valid index at or after ptr, modulo 4.
module rr_pick4 (
    input  logic [3:0] in_valid,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any_valid
);
    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest valid index overwrites last.
    always_comb begin
        winner    = 2'd0;
        any_valid = 1'b0;
        idx       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (in_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux4_rr_scheduler.sv
// Four requesters share one registered output slot; grants rotate round-robin after each transfer.
module mux4_rr_scheduler #(
    parameter int DATA_W = mux4_rr_scheduler_pkg::DATA_W,
    parameter int N_REQ  = mux4_rr_scheduler_pkg::N_REQ
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     in_valid,
    input  logic [DATA_W-1:0]    in_data_0,
    input  logic [DATA_W-1:0]    in_data_1,
    input  logic [DATA_W-1:0]    in_data_2,
    input  logic [DATA_W-1:0]    in_data_3,
    output logic [N_REQ-1:0]     in_ready,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic [1:0]           out_src,
    input  logic                 out_ready,
    output logic                 busy
);
    import mux4_rr_scheduler_pkg::*;

    state_e                      state;
    logic [SRC_W-1:0]            ptr;
    logic [SRC_W-1:0]            winner;
    logic                        any_valid;
    logic                        can_load;
    logic                        xfer;
    logic [3:0][DATA_W-1:0]      in_data_arr;

    assign in_data_arr = {in_data_3, in_data_2, in_data_1, in_data_0};

    rr_pick4 u_pick (
        .in_valid  (in_valid),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign can_load = (state == ST_EMPTY) || out_ready;

    // Gating with reset keeps requesters from seeing an accept that the reset edge would discard.
    always_comb begin
        in_ready = '0;
        if (!reset && can_load && any_valid)
            in_ready[winner] = 1'b1;
    end

    assign xfer      = |(in_valid & in_ready);
    assign out_valid = (state == ST_FULL);
    assign busy      = out_valid || (|in_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_EMPTY;
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            state    <= ST_FULL;
            out_data <= in_data_arr[winner];
            out_src  <= winner;
            ptr      <= winner + 2'd1;
        end else if (state == ST_FULL && out_ready) begin
            // Drain only; data and source hold their last values.
            state    <= ST_EMPTY;
        end
    end
endmodule
